// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB3 master with a bounded wait on pready.
// One transfer outstanding at a time; every output comes straight from a register.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Counter stops at the last tolerated wait; with the timeout disabled it simply pins at all-ones.
  localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'hFFFF : 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg;
  logic        cmd_ready_reg, rsp_valid_reg, rsp_err_reg;
  logic        psel_reg, penable_reg, pwrite_reg;
  logic [31:0] paddr_reg, pwdata_reg, rsp_rdata_reg;
  logic        accept, timeout_hit;

  assign accept      = (state_reg == IDLE) && cmd_valid_i && cmd_ready_reg;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST) && !pready_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      // Control outputs are decoded from the next state so they line up with the state they describe.
      cmd_ready_reg <= (state_next == IDLE);
      psel_reg      <= (state_next == SETUP) || (state_next == ACCESS);
      penable_reg   <= (state_next == ACCESS);
      rsp_valid_reg <= (state_next == RESP);

      if (accept) begin
        pwrite_reg <= cmd_write_i;
        paddr_reg  <= cmd_addr_i;
        pwdata_reg <= cmd_wdata_i;
      end

      if (state_reg == SETUP) begin
        cnt_reg <= '0;
      end else if (state_reg == ACCESS) begin
        if (pready_i) begin
          rsp_err_reg   <= pslverr_i;
          rsp_rdata_reg <= (!pwrite_reg && !pslverr_i) ? prdata_i : 32'd0;
        end else if (timeout_hit) begin
          rsp_err_reg   <= 1'b1;
          rsp_rdata_reg <= 32'd0;
        end else if (cnt_reg != CNT_LAST) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  end

  assign cmd_ready_o = cmd_ready_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign psel_o      = psel_reg;
  assign penable_o   = penable_reg;
  assign pwrite_o    = pwrite_reg;
  assign paddr_o     = paddr_reg;
  assign pwdata_o    = pwdata_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: bench-side APB slave, response scoreboard,
// cycle-accurate latency checks, timeout, slave error, back-pressure and mid-transfer reset.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_ready;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        cmd_ready_o, rsp_valid_o, rsp_err_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [32:0] sb_q[$];

  apb_master_bridge #(.TIMEOUT(4)) dut (
    .pclk_i(pclk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One full transfer, entered and left at a falling edge. waits = pready-low ACCESS cycles,
  // hang = pready never rises, hold = cycles the response is back-pressured.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] prd, input int waits, input bit slverr,
                        input bit hang, input int hold);
    int n;
    int acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [32:0] got;
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check_eq("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b0; pslverr = slverr; prdata = prd;
    rsp_ready = (hold == 0);
    exp_err   = hang ? 1'b1 : slverr;
    exp_rdata = (hang || wr || slverr) ? 32'd0 : prd;
    sb_q.push_back({exp_err, exp_rdata});
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    check_eq("setup_psel", 32'(psel_o), 32'd1);
    check_eq("setup_penable", 32'(penable_o), 32'd0);
    check_eq("setup_cmd_ready", 32'(cmd_ready_o), 32'd0);
    check_eq("setup_paddr", paddr_o, addr);
    check_eq("setup_pwdata", pwdata_o, wdata);
    check_eq("setup_pwrite", 32'(pwrite_o), 32'(wr));
    acc = 0;
    @(negedge pclk);
    while (psel_o && penable_o && acc < 50) begin
      acc++;
      check_eq("access_paddr", paddr_o, addr);
      check_eq("access_pwdata", pwdata_o, wdata);
      check_eq("access_pwrite", 32'(pwrite_o), 32'(wr));
      check_eq("access_rsp_valid", 32'(rsp_valid_o), 32'd0);
      pready = !hang && (acc > waits);
      @(negedge pclk);
    end
    check_eq("access_len", 32'(acc), hang ? 32'd4 : 32'(waits + 1));
    check_eq("resp_psel", 32'(psel_o), 32'd0);
    check_eq("resp_penable", 32'(penable_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_valid", 32'(rsp_valid_o), 32'd1);
      check_eq("hold_rdata", rsp_rdata_o, exp_rdata);
      check_eq("hold_err", 32'(rsp_err_o), 32'(exp_err));
      check_eq("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    check_eq("resp_valid", 32'(rsp_valid_o), 32'd1);
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_eq("rsp_rdata", rsp_rdata_o, got[31:0]);
      check_eq("rsp_err", 32'(rsp_err_o), 32'(got[32]));
    end
    @(negedge pclk);
    pslverr = 1'b0;
    check_eq("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
  endtask

  int start_cyc;
  int burst_addr[7] = '{2, 4, 5, 6, 7, 8, 3};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    #1;
    check_eq("rst_outputs", {26'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o}, 32'd0);
    check_eq("rst_data", paddr_o | pwdata_o | rsp_rdata_o, 32'd0);
    repeat (2) @(negedge pclk);
    check_eq("rst_cmd_ready_held", 32'(cmd_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge pclk);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

    do_txn(1'b1, 32'd2, 32'h0000_000F, 32'h0, 0, 1'b0, 1'b0, 0);
    do_txn(1'b0, 32'd6, 32'h0, 32'h0000_0002, 2, 1'b0, 1'b0, 0);
    do_txn(1'b0, 32'd9, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b1, 0);
    do_txn(1'b0, 32'd1, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, 0);
    do_txn(1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0, 5);
    do_txn(1'b1, 32'h20, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 2);
    for (int k = 0; k < 4; k++)
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2));

    // Reset in the middle of ACCESS: nothing may come back for the aborted command.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h55; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check_eq("midrst_in_access", 32'({psel_o, penable_o}), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ctrl", {26'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, psel_o, penable_o, pwrite_o}, 32'd0);
    check_eq("midrst_data", paddr_o | pwdata_o | rsp_rdata_o, 32'd0);
    @(negedge pclk);
    rst = 1'b0; pready = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      check_eq("midrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    end

    start_cyc = cyc;
    foreach (burst_addr[i])
      do_txn(1'b1, 32'(burst_addr[i]), 32'(i) + 32'h100, 32'h0, 0, 1'b0, 1'b0, 0);
    check_eq("burst_cycles", 32'(cyc - start_cyc), 32'd28);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
